// File: rtl/uart_prog_loader.sv
// UART 8N1 boot loader: 16-bit little-endian length, then little-endian 32-bit words to instruction memory.
// mem_we fires 2 clk after the 4th stop sample; no backpressure, the memory port must accept every strobe.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              UartOver,
  output logic              load_err,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]   MAX_LEN = 17'(1 << ADDR_W);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LD_LEN0 = 3'd0;
  localparam logic [2:0] LD_LEN1 = 3'd1;
  localparam logic [2:0] LD_DATA = 3'd2;
  localparam logic [2:0] LD_DONE = 3'd3;
  localparam logic [2:0] LD_ERR  = 3'd4;

  logic          rx_s1, rx_s2;
  logic [1:0]    rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_valid, frame_err, start_ok;

  logic [2:0]    ld_state;
  logic [15:0]   len;
  logic [ADDR_W:0] idx;
  logic [1:0]    kb;
  logic [23:0]   word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      start_ok   <= 1'b0;
    end else begin
      rx_s1      <= uart_rx;
      rx_s2      <= rx_s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      start_ok   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_state <= RX_START;
            cnt      <= '0;
          end
        end
        RX_START: begin
          // Half-bit re-sample rejects glitches shorter than half a bit.
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              start_ok <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_M1) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == BIT_M1) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) byte_valid <= 1'b1;
            else       frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state  <= LD_LEN0;
      len       <= '0;
      idx       <= '0;
      kb        <= '0;
      word      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok && ld_state == LD_LEN0) busy <= 1'b1;
      // Completion is decided in the strobe cycle, so UartOver follows the last write by one clk.
      if (mem_we) begin
        idx <= idx + 1'b1;
        if (17'(idx) + 17'd1 == {1'b0, len}) begin
          ld_state <= LD_DONE;
          busy     <= 1'b0;
        end
      end
      if (frame_err && (ld_state == LD_LEN0 || ld_state == LD_LEN1 || ld_state == LD_DATA)) begin
        ld_state <= LD_ERR;
        busy     <= 1'b0;
      end else if (byte_valid) begin
        case (ld_state)
          LD_LEN0: begin
            len[7:0] <= shreg;
            ld_state <= LD_LEN1;
          end
          LD_LEN1: begin
            len[15:8] <= shreg;
            if ({shreg, len[7:0]} == 16'd0) begin
              ld_state <= LD_DONE;
              busy     <= 1'b0;
            end else if ({1'b0, shreg, len[7:0]} > MAX_LEN) begin
              ld_state <= LD_ERR;
              busy     <= 1'b0;
            end else begin
              ld_state <= LD_DATA;
            end
          end
          LD_DATA: begin
            kb <= kb + 1'b1;
            case (kb)
              2'd0: word[7:0]   <= shreg;
              2'd1: word[15:8]  <= shreg;
              2'd2: word[23:16] <= shreg;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= idx[ADDR_W-1:0];
                mem_wdata <= {shreg, word};
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign UartOver = (ld_state == LD_DONE);
  assign load_err = (ld_state == LD_ERR);

endmodule
